// File: rtl/fupconvert.sv
// ============================================================================
// fupconvert : I/Q pair framing, LO mixing and saturating 16-bit DAC output
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fupconvert #(
  parameter int out_dw = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [15:0]       iq_data,
  input  logic                     iq_gate,
  input  logic                     iq_trig,
  input  logic signed [17:0]       cosd,
  input  logic signed [17:0]       sind,
  input  logic                     err_clear,
  output logic signed [out_dw-1:0] d_out,
  output logic                     d_valid,
  output logic                     time_err,
  output logic [7:0]               err_cnt
);

  localparam logic signed [34:0] c_pos_lim = 35'sd32767;
  localparam logic signed [34:0] c_neg_lim = -35'sd32768;

  // Framing state and pair staging
  logic               prev_trig_q;
  logic               icap_q;
  logic               armed_q;
  logic signed [15:0] i_stage_q;
  logic signed [15:0] pair_iv_q, pair_iv_d;
  logic signed [15:0] pair_qv_q, pair_qv_d;
  logic               pair_ok_q, pair_ok_d;

  // Mixing pipeline
  logic signed [17:0] cos_q, sin_q;
  logic signed [33:0] prod_ic_q, prod_qs_q;
  logic               ok1_q;
  logic signed [34:0] diff_q;
  logic               ok2_q;
  logic signed [15:0] d_out_q, d_out_d;
  logic               d_valid_q;

  logic               time_err_q;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               w_fault;
  logic signed [34:0] w_shift;
  logic signed [33:0] w_prod_ic, w_prod_qs;

  assign w_fault   = armed_q && ((iq_trig == prev_trig_q) || !iq_gate);
  assign w_prod_ic = 34'(pair_iv_q) * 34'(cos_q);
  assign w_prod_qs = 34'(pair_qv_q) * 34'(sin_q);
  assign w_shift   = diff_q >>> 17;

  always_comb begin
    pair_iv_d = pair_iv_q;
    pair_qv_d = pair_qv_q;
    pair_ok_d = pair_ok_q;
    // A Q slot is a low trig directly after a high one; an ungated slot zeroes the pair
    if (!iq_trig && prev_trig_q) begin
      if (icap_q && iq_gate) begin
        pair_iv_d = i_stage_q;
        pair_qv_d = iq_data;
        pair_ok_d = 1'b1;
      end else begin
        pair_iv_d = '0;
        pair_qv_d = '0;
        pair_ok_d = 1'b0;
      end
    end

    if (w_shift > c_pos_lim) begin
      d_out_d = 16'sh7FFF;
    end else if (w_shift < c_neg_lim) begin
      d_out_d = -16'sh8000;
    end else begin
      d_out_d = w_shift[15:0];
    end

    err_cnt_d = err_cnt_q;
    if (err_clear) begin
      err_cnt_d = '0;
    end else if (w_fault && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_trig_q <= 1'b0;
      icap_q      <= 1'b0;
      armed_q     <= 1'b0;
      i_stage_q   <= '0;
      pair_iv_q   <= '0;
      pair_qv_q   <= '0;
      pair_ok_q   <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
      prod_ic_q   <= '0;
      prod_qs_q   <= '0;
      ok1_q       <= 1'b0;
      diff_q      <= '0;
      ok2_q       <= 1'b0;
      d_out_q     <= '0;
      d_valid_q   <= 1'b0;
      time_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_trig_q <= iq_trig;
      icap_q      <= iq_trig && iq_gate;
      if (iq_trig && iq_gate) begin
        armed_q   <= 1'b1;
        i_stage_q <= iq_data;
      end
      pair_iv_q   <= pair_iv_d;
      pair_qv_q   <= pair_qv_d;
      pair_ok_q   <= pair_ok_d;
      cos_q       <= cosd;
      sin_q       <= sind;
      prod_ic_q   <= w_prod_ic;
      prod_qs_q   <= w_prod_qs;
      ok1_q       <= pair_ok_q;
      diff_q      <= 35'(prod_ic_q) - 35'(prod_qs_q);
      ok2_q       <= ok1_q;
      d_out_q     <= d_out_d;
      d_valid_q   <= ok2_q;
      time_err_q  <= w_fault;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign d_out    = d_out_q;
  assign d_valid  = d_valid_q;
  assign time_err = time_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fupconvert.sv
// ============================================================================
// tb_fupconvert : scoreboard bench with a behavioural pair/mix/framing model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fupconvert;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] iq_data = '0;
  logic               iq_gate = 1'b0;
  logic               iq_trig = 1'b0;
  logic signed [17:0] cosd = '0;
  logic signed [17:0] sind = '0;
  logic               err_clear = 1'b0;
  logic signed [15:0] d_out;
  logic               d_valid;
  logic               time_err;
  logic [7:0]         err_cnt;

  always #5 clk = ~clk;

  fupconvert #(.out_dw(16)) dut (
    .clk(clk), .rst(rst), .iq_data(iq_data), .iq_gate(iq_gate),
    .iq_trig(iq_trig), .cosd(cosd), .sind(sind), .err_clear(err_clear),
    .d_out(d_out), .d_valid(d_valid), .time_err(time_err), .err_cnt(err_cnt)
  );

  typedef struct {
    int d;
    int v;
    int te;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int m_prev_trig = 0, m_icap = 0, m_armed = 0, m_istage = 0;
  int m_pi = 0, m_pq = 0, m_ok = 0, m_cnt = 0;
  int hv[$]  = '{0, 0, 0};
  int hok[$] = '{0, 0, 0};

  function automatic int mix(int i, int q, int c, int s);
    longint p, f;
    p = longint'(i) * longint'(c) - longint'(q) * longint'(s);
    f = p / 131072;
    if (p < 0 && (p % 131072) != 0) f = f - 1;
    if (f > 32767)  return 32767;
    if (f < -32768) return -32768;
    return int'(f);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic step(input bit r, input bit t, input bit g, input int data,
                      input int c, input int s, input bit clr);
    exp_t e;
    bit   fault;
    @(negedge clk);
    rst = r; iq_trig = t; iq_gate = g; err_clear = clr;
    iq_data = 16'(data); cosd = 18'(c); sind = 18'(s);
    if (r) begin
      m_prev_trig = 0; m_icap = 0; m_armed = 0; m_istage = 0;
      m_pi = 0; m_pq = 0; m_ok = 0; m_cnt = 0;
      hv = '{0, 0, 0}; hok = '{0, 0, 0};
      e.d = 0; e.v = 0; e.te = 0;
    end else begin
      fault = (m_armed != 0) && ((int'(t) == m_prev_trig) || !g);
      e.te = int'(fault);
      if (clr) m_cnt = 0;
      else if (fault && m_cnt < 255) m_cnt++;
      if (t && g) m_armed = 1;
      if (!t && m_prev_trig != 0) begin
        if (m_icap != 0 && g) begin m_pi = m_istage; m_pq = data; m_ok = 1; end
        else begin m_pi = 0; m_pq = 0; m_ok = 0; end
      end
      if (t && g) m_istage = data;
      m_icap = int'(t && g);
      m_prev_trig = int'(t);
      hv.push_back(mix(m_pi, m_pq, c, s));
      hok.push_back(m_ok);
      e.d = hv.pop_front();
      e.v = hok.pop_front();
    end
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic pair(input int i, input int q, input bit gi, input bit gq,
                      input int c, input int s);
    step(0, 1, gi, i, c, s, 0);
    step(0, 0, gq, q, c, s, 0);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic int rnd_lo();
    if ($urandom_range(19) == 0) return -131072;
    return int'($urandom_range(262143)) - 131072;
  endfunction

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("d_out",    int'(d_out),    e.d);
        chk("d_valid",  int'(d_valid),  e.v);
        chk("time_err", int'(time_err), e.te);
        chk("err_cnt",  int'(err_cnt),  e.cnt);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (6) pair(16384, 0, 1, 1, 131071, 0);
    repeat (6) pair(0, 16384, 1, 1, 0, 131071);
    repeat (4) pair(32767, -32768, 1, 1, 131071, 131071);
    repeat (4) pair(-32768, 32767, 1, 1, 131071, 131071);
    repeat (4) pair(rnd16(), rnd16(), 1, 1, -131072, rnd_lo());
    repeat (4) pair(rnd16(), rnd16(), 1, 1, rnd_lo(), -131072);
    repeat (2) pair(-32768, -32768, 1, 1, -131072, -131072);
    // Gate drop on a Q slot, then recovery
    pair(1000, 2000, 1, 0, 90000, 40000);
    repeat (4) pair(1000, 2000, 1, 1, 90000, 40000);
    // I slot repeated once
    step(0, 1, 1, 5000, 100000, 20000, 0);
    step(0, 1, 1, 6000, 100000, 20000, 0);
    step(0, 0, 1, 7000, 100000, 20000, 0);
    repeat (4) pair(3000, -4000, 1, 1, 100000, 20000);
    // Long fault run saturates the counter, then clear on a faulting edge
    repeat (300) step(0, 1, 1, 100, 50000, 50000, 0);
    step(0, 1, 1, 100, 50000, 50000, 1);
    step(0, 0, 1, 200, 50000, 50000, 0);
    repeat (3) pair(-1234, 4321, 1, 1, 50000, 50000);
    // One-cycle reset after an I slot discards the half pair
    pair(8000, 9000, 1, 1, 120000, -60000);
    step(0, 1, 1, 8000, 120000, -60000, 0);
    step(1, 0, 1, 9000, 120000, -60000, 0);
    step(0, 0, 1, 9000, 120000, -60000, 0);
    repeat (6) pair(8000, 9000, 1, 1, 120000, -60000);
    // Randomised stream with occasional faults, clears and resets
    repeat (400) begin
      int sel;
      int c, s;
      sel = int'($urandom_range(99));
      c = rnd_lo(); s = rnd_lo();
      if (sel < 3) step(1, 0, 0, rnd16(), c, s, 0);
      else if (sel < 8) step(0, 1, 1, rnd16(), c, s, 0);
      else if (sel < 12) pair(rnd16(), rnd16(), $urandom_range(1), $urandom_range(1), c, s);
      else if (sel < 15) step(0, $urandom_range(1), 1, rnd16(), c, s, 1);
      else pair(rnd16(), rnd16(), 1, 1, c, s);
    end
    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fupconvert.md
FUPCONVERT -- requirements
Module: fupconvert

Interface
REQ-001 Parameter: out_dw, default 16, DAC output width; fixed at 16, other values unsupported.
REQ-002 clk  input  1  single clock, all logic on rising edge, timespec 6.66 ns.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 iq_data  input  16 signed  interleaved I/Q stream.
REQ-005 iq_gate  input  1  iq_data valid this cycle.
REQ-006 iq_trig  input  1  high = I slot, low = Q slot (Q follows I on the next cycle).
REQ-007 cosd  input  18 signed  LO cosine; -131072 is an invalid LO value.
REQ-008 sind  input  18 signed  LO sine; -131072 is an invalid LO value.
REQ-009 err_clear  input  1  clears err_cnt.
REQ-010 d_out  output  16 signed  upconverted DAC sample, one per clk.
REQ-011 d_valid  output  1  d_out derived from a complete gated I/Q pair.
REQ-012 time_err  output  1  registered one-cycle pulse on a framing fault.
REQ-013 err_cnt  output  8  saturating count of time_err pulses.

Function
REQ-014 I capture: the block shall load i_stage from iq_data on an edge where iq_trig=1 and iq_gate=1.
REQ-015 Pair load: on an edge where iq_trig=0, the previous cycle was a captured I slot, and iq_gate=1, the pair register shall load {i_stage, iq_data} and set pair_ok=1.
REQ-016 Pair persistence: the pair register shall hold its contents between loads, so each pair drives two consecutive d_out samples at full rate.
REQ-017 Missing gate: iq_gate=0 in either slot of a pair shall load the pair register with {0,0} and pair_ok=0 at the Q-slot edge.
REQ-018 Mixing: d_out shall equal SAT16((I*cosd - Q*sind) >>> 17), using full-precision 34-bit products and a 35-bit difference.
REQ-019 Rounding: >>> is an arithmetic shift with floor (truncation toward minus infinity).
REQ-020 Saturation: SAT16 shall clip to +32767 / -32768 and never wrap.
REQ-021 Pipeline: LO register, product register, difference register, then saturate/output register.
REQ-022 LO latency: d_out after edge N+3 shall use cosd/sind sampled at edge N and the pair register contents just after edge N.
REQ-023 Pair latency: a pair loaded at edge M shall first appear in d_out after edge M+3.
REQ-024 d_valid shall equal pair_ok, delayed by the same 3-edge pipeline as the data.
REQ-025 Framing fault: iq_trig equal on two consecutive cycles, or iq_gate=0 while the checker is armed, shall set time_err=1 on the following edge for one cycle per offending cycle.
REQ-026 Checker arming: the checker shall arm on the first edge with iq_trig=1 and iq_gate=1 after reset, and shall never flag before arming.
REQ-027 Error counter: err_cnt shall increment on each time_err pulse and saturate at 255.
REQ-028 Clear priority: err_clear=1 shall zero err_cnt on that edge, with priority over a simultaneous increment.
REQ-029 Invalid LO: cosd or sind = -131072 shall produce a saturated, non-wrapped d_out with no other side effects.

Reset
REQ-030 rst=1 shall on that edge zero all pipeline, stage and pair registers, with d_out=0, d_valid=0, time_err=0, err_cnt=0, and the checker disarmed.
REQ-031 Mid-stream reset: rst asserted mid-stream shall flush the pipeline, with d_out=0 and d_valid=0 from the first edge with rst high.
REQ-032 Post-reset recovery: d_valid shall stay 0 until 3 edges after the first complete pair load following rst deassertion.
REQ-033 A half pair (I captured before reset) shall be discarded.

Verification
REQ-034 Scenario I only: I=16384, Q=0, cosd=131071, sind=0 held -> d_out=16383, d_valid=1 from 3 edges after pair load.
REQ-035 Scenario Q only: I=0, Q=16384, cosd=0, sind=131071 -> d_out=-16384, d_valid=1.
REQ-036 Scenario saturation: I=32767, Q=-32768, cosd=sind=131071 -> d_out=+32767; with I=-32768, Q=32767 -> d_out=-32768, no wrap.
REQ-037 Scenario framing: after arming, iq_trig held high 2 cycles -> one time_err pulse, err_cnt=1; 300 faults -> err_cnt=255; err_clear coincident with a fault -> err_cnt=0.
REQ-038 Scenario gate drop: iq_gate=0 for one Q slot -> that pair gives d_out=0 and d_valid=0 for 2 samples, time_err pulses once, and the next good pair restores d_valid=1.
REQ-039 Scenario reset: rst for 1 cycle mid-stream -> d_out=0 and d_valid=0 immediately, no time_err before re-arming, and valid output resumes 3 edges after the next pair load.
